ascon_perm_engine: RTL and testbench
====================================

ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, rounds evaluated per clock; legal values 1 or 2.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  load byte valid.
REQ-005 SHALL have port in_ready  output  1  load byte accepted when in_valid & in_ready.
REQ-006 SHALL have port in_data  input  8  load byte.
REQ-007 SHALL have port in_xor  input  1  1: XOR byte into state (absorb); 0: overwrite.
REQ-008 SHALL have port start  input  1  single-cycle request to run the permutation.
REQ-009 SHALL have port rounds_sel  input  2  00: 12, 01: 8, 10: 6, 11: 12 rounds.
REQ-010 SHALL have port busy  output  1  high in PERM.
REQ-011 SHALL have port out_valid  output  1  unload byte valid.
REQ-012 SHALL have port out_ready  input  1  unload byte taken when out_valid & out_ready.
REQ-013 SHALL have port out_data  output  8  unload byte.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last unload byte is taken.

Function
REQ-015 SHALL hold a 320-bit state S0..S4; byte index k (0..39) maps to S[k/8] bits [63-8*(k%8) -: 8], big-endian.
REQ-016 SHALL implement FSM states IDLE, PERM, UNLOAD.
REQ-017 IDLE: in_ready=1; each accepted byte writes or XORs into index load_ptr; load_ptr increments and wraps 39->0.
REQ-018 IDLE with start=1: SHALL latch rounds_sel, clear load_ptr, and enter PERM next cycle; a byte accepted in the same cycle SHALL be included.
REQ-019 PERM: in_ready=0, busy=1, start ignored; each cycle SHALL apply UNROLL rounds; round j (0..11) uses constant ((15-j)<<4)|j, starting at j=12-r for r rounds.
REQ-020 Latency: PERM SHALL last exactly r/UNROLL cycles, then enter UNLOAD.
REQ-021 UNLOAD: out_valid=1, out_data=state byte at out_ptr; out_ptr SHALL advance only on handshake; out_data SHALL be stable while out_ready=0.
REQ-022 On the handshake of byte 39: SHALL return to IDLE, clear out_ptr, and pulse done for one cycle.
REQ-023 State SHALL be unchanged by UNLOAD and retained in IDLE, so a subsequent in_xor load performs absorption.
REQ-024 in_valid outside IDLE SHALL be ignored; out_ready outside UNLOAD SHALL be ignored.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, state=0, load_ptr=out_ptr=0, and round counter=0.
REQ-026 Outputs SHALL be in reset: in_ready=0, busy=0, out_valid=0, out_data=0, done=0; in_ready SHALL rise the first cycle after deassertion.
REQ-027 Reset during PERM or UNLOAD SHALL abort with no done pulse.

Structure
REQ-028 Package ascon_pkg SHALL hold the state width (320), lane width (64), byte count (40), FSM state enum, and round-constant function.
REQ-029 Sub-module ascon_round SHALL implement one combinational round (constant add, 5-bit S-box, linear diffusion layer); the engine SHALL instantiate it UNROLL times in a chain.

Verification
REQ-030 Load 40 zero bytes, rounds_sel=00, UNROLL=1 -> busy high exactly 12 cycles; 40 output bytes equal the C reference p12(0).
REQ-031 Same stimulus, UNROLL=2 -> busy high 6 cycles; output identical to REQ-030.
REQ-032 rounds_sel=01, then 10, then 11 on an identical state -> 8, 6, and 12 rounds respectively; 11 matches 00 byte-for-byte.
REQ-033 Load 0x80,0x01..0x27; absorb 8 bytes 0xFF with in_xor=1; run p6 -> output equals the reference p6 of the XORed state.
REQ-034 Random out_ready deassertion during UNLOAD -> no byte lost or repeated, out_data stable while stalled, done exactly once.
REQ-035 rst_n low at the 5th PERM cycle -> all outputs 0, no done, and a following clean run matches REQ-030.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared sizes, FSM encoding and round-constant helpers for the Ascon permutation engine.
package ascon_pkg;

  localparam int STATE_W = 320;
  localparam int LANE_W  = 64;
  localparam int NBYTES  = 40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PERM   = 2'd1,
    ST_UNLOAD = 2'd2
  } fsm_state_e;

  // Round j (0..11) adds ((15-j) << 4) | j into lane 2.
  function automatic logic [7:0] round_const(input logic [3:0] j);
    return {4'd15 - j, j};
  endfunction

  // A run of r rounds uses the last r constants, i.e. starts at j = 12 - r.
  function automatic logic [3:0] first_round(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd4;
      2'b10:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced 5-bit S-box, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] s_in,
  input  logic [7:0]         rc,
  output logic [STATE_W-1:0] s_out
);

  function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

  logic [LANE_W-1:0] x0, x1, x2, x3, x4;
  logic [LANE_W-1:0] a0, a1, a2, a3, a4;
  logic [LANE_W-1:0] b0, b1, b2, b3, b4;
  logic [LANE_W-1:0] c0, c1, c2, c3, c4;

  // Lane 0 occupies the most significant 64 bits of the flat state.
  assign x0 = s_in[319:256];
  assign x1 = s_in[255:192];
  assign x2 = s_in[191:128] ^ {56'd0, rc};
  assign x3 = s_in[127:64];
  assign x4 = s_in[63:0];

  assign a0 = x0 ^ x4;
  assign a1 = x1;
  assign a2 = x2 ^ x1;
  assign a3 = x3;
  assign a4 = x4 ^ x3;

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign s_out = {c0 ^ ror(c0, 19) ^ ror(c0, 28),
                  c1 ^ ror(c1, 61) ^ ror(c1, 39),
                  c2 ^ ror(c2, 1)  ^ ror(c2, 6),
                  c3 ^ ror(c3, 10) ^ ror(c3, 17),
                  c4 ^ ror(c4, 7)  ^ ror(c4, 41)};

endmodule

// File: rtl/ascon_perm_engine.sv
// Byte-serial load/unload wrapper around an UNROLL-deep chain of Ascon rounds (UNROLL = 1 or 2).
module ascon_perm_engine
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_xor,
  input  logic       start,
  input  logic [1:0] rounds_sel,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       done,
  output fsm_state_e dbg_state
);

  // Handshakes: a byte moves on a rising edge where valid & ready are both high;
  // out_data is held while out_valid is high and out_ready is low.

  localparam logic [3:0] STEP = 4'(UNROLL);
  localparam logic [3:0] LAST = 4'd12;
  localparam logic [5:0] MAX_PTR = 6'(NBYTES - 1);

  fsm_state_e         fsm_q;
  logic [STATE_W-1:0] perm_state;
  logic [5:0]         load_ptr;
  logic [5:0]         out_ptr;
  logic [3:0]         rnd_idx;
  logic [8:0]         load_lsb;
  logic [8:0]         out_lsb;
  logic               load_fire;
  logic [STATE_W-1:0] chain [UNROLL+1];

  // Byte k is big-endian within its lane, so it sits at flat bits [319-8k -: 8].
  assign load_lsb  = 9'd312 - {load_ptr, 3'b000};
  assign out_lsb   = 9'd312 - {out_ptr, 3'b000};
  assign load_fire = (fsm_q == ST_IDLE) && in_valid && in_ready;
  assign out_data  = out_valid ? perm_state[out_lsb +: 8] : 8'd0;
  assign dbg_state = fsm_q;

  assign chain[0] = perm_state;
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    ascon_round u_round (
      .s_in  (chain[u]),
      .rc    (round_const(rnd_idx + 4'(u))),
      .s_out (chain[u+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_IDLE;
      perm_state <= '0;
      load_ptr   <= 6'd0;
      out_ptr    <= 6'd0;
      rnd_idx    <= 4'd0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (load_fire) begin
            perm_state[load_lsb +: 8] <= in_xor ? (perm_state[load_lsb +: 8] ^ in_data) : in_data;
            load_ptr <= (load_ptr == MAX_PTR) ? 6'd0 : load_ptr + 6'd1;
          end
          // A byte accepted together with start lands before the first round.
          if (start) begin
            load_ptr <= 6'd0;
            rnd_idx  <= first_round(rounds_sel);
            fsm_q    <= ST_PERM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_PERM: begin
          perm_state <= chain[UNROLL];
          if (rnd_idx + STEP == LAST) begin
            rnd_idx   <= 4'd0;
            fsm_q     <= ST_UNLOAD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            rnd_idx <= rnd_idx + STEP;
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (out_ptr == MAX_PTR) begin
              out_ptr   <= 6'd0;
              fsm_q     <= ST_IDLE;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              done      <= 1'b1;
            end else begin
              out_ptr <= out_ptr + 6'd1;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine: UNROLL=1 and UNROLL=2 instances against a table-driven reference.
module tb_ascon_perm_engine;
  import ascon_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid [2];
  logic       in_ready [2];
  logic [7:0] in_data [2];
  logic       in_xor [2];
  logic       start [2];
  logic [1:0] rounds_sel [2];
  logic       busy [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data [2];
  logic       done [2];
  fsm_state_e dbg_state [2];

  logic [63:0] m_s [2][5];
  int          m_ptr [2];
  logic [7:0]  exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          busy_cnt [2];
  int          done_cnt [2];
  logic        held_v [2];
  logic [7:0]  held_d [2];
  int          stall_pct = 0;
  logic [7:0]  pat [40];
  logic [1:0]  sels [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [4:0]  sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  ascon_perm_engine #(.UNROLL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_xor(in_xor[0]), .start(start[0]), .rounds_sel(rounds_sel[0]),
    .busy(busy[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .done(done[0]), .dbg_state(dbg_state[0])
  );

  ascon_perm_engine #(.UNROLL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_xor(in_xor[1]), .start(start[1]), .rounds_sel(rounds_sel[1]),
    .busy(busy[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .done(done[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror64(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic int rounds_of(logic [1:0] s);
    if (s == 2'b01) return 8;
    if (s == 2'b10) return 6;
    return 12;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) m_s[d][i] = 64'd0;
      m_ptr[d] = 0;
    end
  endtask

  task automatic model_load(int d, logic [7:0] b, logic x);
    int k;
    logic [7:0] cur;
    k = m_ptr[d];
    cur = m_s[d][k/8][63-8*(k%8) -: 8];
    m_s[d][k/8][63-8*(k%8) -: 8] = x ? (cur ^ b) : b;
    m_ptr[d] = (k + 1) % 40;
  endtask

  task automatic model_perm(int d, int r);
    logic [63:0] x [5];
    logic [4:0] idx;
    logic [4:0] o;
    for (int i = 0; i < 5; i++) x[i] = m_s[d][i];
    for (int j = 12 - r; j < 12; j++) begin
      x[2] = x[2] ^ 64'((15 - j) * 16 + j);
      for (int b = 0; b < 64; b++) begin
        idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox[idx];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
      x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
      x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
      x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
      x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
    end
    for (int i = 0; i < 5; i++) m_s[d][i] = x[i];
  endtask

  task automatic push_expected(int d);
    for (int k = 0; k < 40; k++) exp_q.push_back(m_s[d][k/8][63-8*(k%8) -: 8]);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy[d]) busy_cnt[d]++;
      if (done[d]) done_cnt[d]++;
      if (out_valid[d]) begin
        if (held_v[d]) check("unload_stable", 32'(out_data[d]), 32'(held_d[d]));
        if (out_ready[d]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unload_extra_byte got=%0h exp=none", out_data[d]);
          end else begin
            check("unload_byte", 32'(out_data[d]), 32'(exp_q.pop_front()));
          end
        end
        held_v[d] = !out_ready[d];
        held_d[d] = out_data[d];
      end else begin
        held_v[d] = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) out_ready[d] = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_outputs_zero(int d, string tag);
    check({tag, "_in_ready"}, 32'(in_ready[d]), 32'd0);
    check({tag, "_busy"}, 32'(busy[d]), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
    check({tag, "_out_data"}, 32'(out_data[d]), 32'd0);
    check({tag, "_done"}, 32'(done[d]), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("ready_before_first_edge", 32'(in_ready[d]), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("ready_after_reset", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_outputs_zero(d, "reset");
    model_clear();
    exp_q.delete();
    release_reset();
  endtask

  task automatic load_byte(int d, logic [7:0] b, logic x);
    in_valid[d] = 1'b1;
    in_data[d] = b;
    in_xor[d] = x;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    model_load(d, b, x);
  endtask

  task automatic run_perm(int d, logic [1:0] sel, logic with_byte, logic [7:0] b, logic x);
    int r;
    int t;
    r = rounds_of(sel);
    busy_cnt[d] = 0;
    done_cnt[d] = 0;
    if (with_byte) begin
      in_valid[d] = 1'b1;
      in_data[d] = b;
      in_xor[d] = x;
    end
    start[d] = 1'b1;
    rounds_sel[d] = sel;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    in_valid[d] = 1'b0;
    if (with_byte) model_load(d, b, x);
    m_ptr[d] = 0;
    model_perm(d, r);
    push_expected(d);
    // Loads and a second start during PERM must be ignored.
    in_valid[d] = 1'b1;
    in_data[d] = 8'($urandom);
    in_xor[d] = 1'($urandom);
    start[d] = 1'b1;
    rounds_sel[d] = ~sel;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    t = 0;
    while (done_cnt[d] == 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt[d]), 32'd1);
    check("busy_cycles", 32'(busy_cnt[d]), 32'(r / (d + 1)));
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("idle_in_ready", 32'(in_ready[d]), 32'd1);
    check("idle_state", 32'(dbg_state[d]), 32'(ST_IDLE));
    exp_q.delete();
  endtask

  task automatic load_zeros(int d);
    for (int k = 0; k < 40; k++) load_byte(d, 8'h00, 1'b0);
  endtask

  task automatic abort_in_perm(int d);
    load_zeros(d);
    busy_cnt[d] = 0;
    done_cnt[d] = 0;
    start[d] = 1'b1;
    rounds_sel[d] = 2'b00;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero(d, "abort");
    check("abort_busy_before", 32'(busy_cnt[d]), 32'd4);
    check("abort_state", 32'(dbg_state[d]), 32'(ST_IDLE));
    model_clear();
    exp_q.delete();
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt[d]), 32'd0);
    load_zeros(d);
    run_perm(d, 2'b00, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    int n;
    logic wb;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 8'h00; in_xor[i] = 1'b0;
      start[i] = 1'b0; rounds_sel[i] = 2'b00; out_ready[i] = 1'b0;
      busy_cnt[i] = 0; done_cnt[i] = 0; held_v[i] = 1'b0; held_d[i] = 8'h00;
    end
    do_reset();

    for (int i = 0; i < 2; i++) begin
      load_zeros(i);
      run_perm(i, 2'b00, 1'b0, 8'h00, 1'b0);
    end

    stall_pct = 30;
    foreach (pat[k]) pat[k] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      foreach (sels[s]) begin
        for (int k = 0; k < 40; k++) load_byte(i, pat[k], 1'b0);
        run_perm(i, sels[s], 1'b0, 8'h00, 1'b0);
      end
    end

    for (int i = 0; i < 2; i++) begin
      load_byte(i, 8'h80, 1'b0);
      for (int k = 1; k < 40; k++) load_byte(i, 8'(k), 1'b0);
      for (int k = 0; k < 8; k++) load_byte(i, 8'hff, 1'b1);
      run_perm(i, 2'b10, 1'b0, 8'h00, 1'b0);
    end

    stall_pct = 60;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 40; k++) load_byte(i, 8'($urandom), 1'($urandom));
      run_perm(i, 2'($urandom), 1'b0, 8'h00, 1'b0);
    end

    stall_pct = 25;
    repeat (6) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(1, 70);
      wb = 1'($urandom);
      for (int k = 0; k < n; k++) load_byte(d, 8'($urandom), 1'($urandom));
      run_perm(d, 2'($urandom), wb, 8'($urandom), 1'($urandom));
    end

    stall_pct = 20;
    abort_in_perm(0);
    abort_in_perm(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
